// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// The ovf wire exists only when NIBBLE_ADDER_OVF_EN is defined.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef NIBBLE_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit ripple stage over WIDTH/4 cycles, LSB nibble first.
// Optional signed-overflow flag: define NIBBLE_ADDER_OVF_EN.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // a valid source holds its payload until that edge, and ready never depends on valid.

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic [4:0]       nib;
  logic             last;

  assign nib  = {1'b0, a_r[3:0]} + {1'b0, b_r[3:0]} + {4'd0, carry};
  assign last = (cnt == CW'(N - 1));

  // New nibble enters at the top so the final result lines up after N steps.
  generate
    if (WIDTH > 4) begin : g_wide
      assign sum_next = {nib[3:0], sum_r[WIDTH-1:4]};
    end else begin : g_narrow
      assign sum_next = nib[3:0];
    end
  endgenerate

`ifdef NIBBLE_ADDER_OVF_EN
  logic ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (state == RUN && last) begin
      // At the last step the low nibble of each operand register holds its sign bit.
      ovf_r <= (a_r[3] == b_r[3]) && (nib[3] != a_r[3]);
    end
  end

  assign bus.ovf = ovf_r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (bus.in_valid && in_ready_r) begin
            a_r        <= bus.a;
            b_r        <= bus.b;
            carry      <= bus.cin;
            cnt        <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          sum_r <= sum_next;
          carry <= nib[4];
          a_r   <= a_r >> 4;
          b_r   <= b_r >> 4;
          cnt   <= cnt + 1'b1;
          if (last) begin
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // in_ready rises only after the result leaves, so accept never overlaps it.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // After the last step the carry register is the carry out of bit WIDTH-1.
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = carry;
  assign busy          = busy_r;
  assign state_dbg     = state;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector and random scoreboard bench for nibble_serial_adder (WIDTH=16 and WIDTH=4).
// Build with NIBBLE_ADDER_OVF_EN defined to also check ovf.
module tb_nibble_serial_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(16)) bus16 ();
  nibble_serial_adder_if #(.WIDTH(4))  bus4 ();

  logic       busy16, busy4;
  logic [1:0] st16, st4;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16), .busy(busy16), .state_dbg(st16)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .busy(busy4), .state_dbg(st4)
  );

  // ---------------- scoreboard ----------------
  int          tests = 0;
  int          fails = 0;
  logic [16:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    int          hold;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[9];

  // ---------------- driver tasks ----------------
  task automatic do_op(input vec_t v, input string tag);
    int n;
    int edges;
    int busy_cnt;
    int rdy_hi;
    n = 0;
    while (!bus16.in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_in_ready_idle"}, bus16.in_ready, 1);
    bus16.in_valid = 1'b1;
    bus16.a        = v.a;
    bus16.b        = v.b;
    bus16.cin      = v.cin;
    tick();
    // Operands after acceptance must have no effect.
    bus16.in_valid = 1'b0;
    bus16.a        = 16'($urandom);
    bus16.b        = 16'($urandom);
    bus16.cin      = 1'($urandom_range(0, 1));
    edges    = 0;
    busy_cnt = 0;
    rdy_hi   = 0;
    while (!bus16.out_valid && edges < 20) begin
      if (busy16) busy_cnt++;
      if (bus16.in_ready) rdy_hi++;
      tick();
      edges++;
    end
    check({tag, "_latency"}, edges, 4);
    check({tag, "_busy_cycles"}, busy_cnt, 4);
    check({tag, "_in_ready_run"}, rdy_hi, 0);
    for (int i = 0; i < v.hold; i++) begin
      bus16.in_valid = 1'b1;
      tick();
      check({tag, "_hold_valid"}, bus16.out_valid, 1);
      check({tag, "_hold_sum"}, {bus16.cout, bus16.sum}, {v.co, v.s});
      check({tag, "_hold_in_ready"}, bus16.in_ready, 0);
    end
    bus16.in_valid = 1'b0;
    check({tag, "_sum"}, bus16.sum, v.s);
    check({tag, "_cout"}, bus16.cout, v.co);
    check({tag, "_busy_done"}, busy16, 0);
`ifdef NIBBLE_ADDER_OVF_EN
    check({tag, "_ovf"}, bus16.ovf, v.ov);
`endif
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;
    check({tag, "_valid_after_hs"}, bus16.out_valid, 0);
    check({tag, "_in_ready_after_hs"}, bus16.in_ready, 1);
  endtask

  task automatic rand_driver();
    logic [15:0] ra, rb;
    logic        rc;
    int          n;
    for (int k = 0; k < 1000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) tick();
      bus16.in_valid = 1'b1;
      bus16.a        = ra;
      bus16.b        = rb;
      bus16.cin      = rc;
      n = 0;
      while (!bus16.in_ready && n < 50) begin
        tick();
        n++;
      end
      if (!bus16.in_ready) begin
        check("rand_accept_timeout", bus16.in_ready, 1);
        bus16.in_valid = 1'b0;
        break;
      end
      exp_q.push_back({1'b0, ra} + {1'b0, rb} + {16'd0, rc});
      tick();
      bus16.in_valid = 1'b0;
    end
  endtask

  task automatic rand_consumer();
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < 1000 && cyc < 30000) begin
      bus16.out_ready = 1'($urandom_range(0, 1));
      if (bus16.out_valid && bus16.out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_result", 1, 0);
        end else begin
          check("rand_result", {bus16.cout, bus16.sum}, exp_q.pop_front());
        end
        got++;
      end
      tick();
      cyc++;
    end
    check("rand_result_count", got, 1000);
    bus16.out_ready = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int n;
    //                a        b        cin hold  sum      cout ovf
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 0, 16'h5556, 1'b0, 1'b0};
    vecs[2] = '{16'hBEEF, 16'h1111, 1'b0, 6, 16'hD000, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'hFFFF, 1'b0, 0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h1234, 16'h0001, 1'b0, 1, 16'h1235, 1'b0, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 0, 16'hFFFF, 1'b1, 1'b0};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 2, 16'h1000, 1'b0, 1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 0, 16'h0000, 1'b1, 1'b1};

    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b0;
    bus4.in_valid  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.cin  = 1'b0; bus4.out_ready  = 1'b0;

    // Reset state.
    #12;
    check("rst_in_ready", bus16.in_ready, 0);
    check("rst_out_valid", bus16.out_valid, 0);
    check("rst_busy", busy16, 0);
    check("rst_sum", bus16.sum, 0);
    check("rst_cout", bus16.cout, 0);
    check("rst_state", st16, 0);
`ifdef NIBBLE_ADDER_OVF_EN
    check("rst_ovf", bus16.ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", bus16.in_ready, 1);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset two edges into RUN aborts the operation.
    bus16.in_valid = 1'b1; bus16.a = 16'hAAAA; bus16.b = 16'h5555; bus16.cin = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    tick();
    tick();
    check("midrun_busy_before", busy16, 1);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_out_valid", bus16.out_valid, 0);
    check("midrun_rst_busy", busy16, 0);
    check("midrun_rst_sum", bus16.sum, 0);
    check("midrun_rst_in_ready", bus16.in_ready, 0);
    check("midrun_rst_state", st16, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("midrun_post_rst_in_ready", bus16.in_ready, 1);
    do_op('{16'h00FF, 16'h0001, 1'b0, 0, 16'h0100, 1'b0, 1'b0}, "after_abort");

    // Throughput: with in_valid and out_ready held high, accepts are N+2 cycles apart.
    bus16.out_ready = 1'b1;
    bus16.in_valid = 1'b1; bus16.a = 16'h0101; bus16.b = 16'h0202; bus16.cin = 1'b0;
    tick();
    n = 0;
    while (!bus16.in_ready && n < 30) begin
      if (bus16.out_valid) check("tput_sum", bus16.sum, 16'h0303);
      tick();
      n++;
    end
    check("tput_gap", n, 5);
    tick();
    bus16.in_valid = 1'b0;
    n = 0;
    while (!bus16.out_valid && n < 20) begin
      tick();
      n++;
    end
    check("tput_second_sum", bus16.sum, 16'h0303);
    tick();
    bus16.out_ready = 1'b0;
    check("tput_drained", bus16.out_valid, 0);

    // WIDTH=4: single RUN edge.
    n = 0;
    while (!bus4.in_ready && n < 20) begin
      tick();
      n++;
    end
    bus4.in_valid = 1'b1; bus4.a = 4'h9; bus4.b = 4'h8; bus4.cin = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    check("w4_busy_run", busy4, 1);
    check("w4_valid_run", bus4.out_valid, 0);
    tick();
    check("w4_out_valid", bus4.out_valid, 1);
    check("w4_sum", bus4.sum, 4'h2);
    check("w4_cout", bus4.cout, 1);
    check("w4_busy_done", busy4, 0);
`ifdef NIBBLE_ADDER_OVF_EN
    check("w4_ovf", bus4.ovf, 1);
`endif
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
    check("w4_valid_after_hs", bus4.out_valid, 0);
    check("w4_in_ready_after_hs", bus4.in_ready, 1);

    // Random back-to-back operations with random backpressure.
    fork
      rand_driver();
      rand_consumer();
    join
    check("rand_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
